// File: rtl/definitions_pkg.sv
// definitions: shared pipeline types.
//   ProgramCounter  - fetch PC width (8 bits)
//   Signal          - control enable encoding (DISABLE=0, ENABLE=1)
//   IF_input        - control bundle consumed by the fetch stage
//   HazState        - fetch_hazard_ctrl FSM states
//   REG_W           - register index width
package definitions;

   localparam int PC_BITS = 8;
   localparam int REG_W   = 3;

   typedef logic [PC_BITS-1:0] ProgramCounter;

   typedef enum logic {
      DISABLE = 1'b0,
      ENABLE  = 1'b1
   } Signal;

   // Fetch redirects when jmp is enabled, or when branch and alu_zero are
   // both set.
   typedef struct packed {
      Signal         stall;
      Signal         jmp;
      ProgramCounter pc_jmp;
      Signal         branch;
      logic          alu_zero;
      ProgramCounter pc_branch;
   } IF_input;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      BUSY_WAIT = 2'd1,
      SHADOW    = 2'd2
   } HazState;

endpackage

// File: rtl/fetch_hazard_ctrl_sat_counter.sv
// sat_counter: synchronous up-counter that sticks at all-ones.
//   clk    in   clock
//   clr    in   synchronous clear (has priority over inc)
//   inc    in   count this cycle
//   count  out  WIDTH-bit current value
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl: hazard / redirect controller for the fetch stage.
// Watches EX busy, taken branches in EX, load-use dependencies and jumps in
// ID, and tells fetch and the IF/ID, ID/EX registers what to do this cycle.
//   clk, reset                  clock, synchronous active-high reset
//   id_*                        ID-stage instruction info
//   ex_*                        EX-stage instruction info
//   if_ctrl                     control bundle to fetch (combinational)
//   flush_ifid / flush_idex     squash IF/ID, bubble ID/EX at next edge
//   hold_ifid / hold_idex       keep register contents at next edge
//   stall_cycles, redirect_cnt  saturating performance counters
module fetch_hazard_ctrl
   import definitions::*;
#(
   parameter int PC_W  = 8,
   parameter int REG_W = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             id_jmp,
   input  logic [PC_W-1:0]  id_jmp_target,
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch,
   input  logic             ex_alu_zero,
   input  logic [PC_W-1:0]  ex_branch_target,
   input  logic             ex_busy,
   output IF_input          if_ctrl,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             hold_ifid,
   output logic             hold_idex,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_cnt
);

   HazState    state_reg;
   HazState    state_next;

   logic       in_shadow;
   logic       branch_ev;
   logic       load_use_ev;
   logic       jump_ev;
   logic       redirect_inc;
   logic       stall_inc;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] redirect_count;

   // ID holds a squashed slot right after a redirect, so its hazards are
   // not real.
   assign in_shadow   = (state_reg == SHADOW);
   assign branch_ev   = ex_valid & ex_branch & ex_alu_zero;
   assign load_use_ev = ~in_shadow & ex_valid & ex_mem_read & id_valid &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_rd)));
   assign jump_ev     = ~in_shadow & id_valid & id_jmp;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // BUSY_WAIT resolves like RUN once ex_busy drops, so only SHADOW needs
   // special treatment (via in_shadow above).
   always_comb begin
      if_ctrl.stall     = DISABLE;
      if_ctrl.jmp       = DISABLE;
      if_ctrl.pc_jmp    = '0;
      if_ctrl.branch    = DISABLE;
      if_ctrl.alu_zero  = 1'b0;
      if_ctrl.pc_branch = '0;
      flush_ifid        = 1'b0;
      flush_idex        = 1'b0;
      hold_ifid         = 1'b0;
      hold_idex         = 1'b0;
      redirect_inc      = 1'b0;
      state_next        = RUN;

      if (reset) begin
         state_next = RUN;
      end else if (ex_busy) begin
         if_ctrl.stall = ENABLE;
         hold_ifid     = 1'b1;
         hold_idex     = 1'b1;
         state_next    = BUSY_WAIT;
      end else begin
         // A not-taken branch still presents branch=1/alu_zero=0 so that
         // fetch's AND yields no redirect.
         if_ctrl.branch   = (ex_valid & ex_branch) ? ENABLE : DISABLE;
         if_ctrl.alu_zero = ex_valid & ex_branch & ex_alu_zero;
         if (branch_ev) begin
            if_ctrl.pc_branch = ex_branch_target;
            flush_ifid        = 1'b1;
            flush_idex        = 1'b1;
            redirect_inc      = 1'b1;
            state_next        = SHADOW;
         end else if (load_use_ev) begin
            if_ctrl.stall = ENABLE;
            hold_ifid     = 1'b1;
            flush_idex    = 1'b1;
         end else if (jump_ev) begin
            if_ctrl.jmp    = ENABLE;
            if_ctrl.pc_jmp = id_jmp_target;
            flush_ifid     = 1'b1;
            redirect_inc   = 1'b1;
            state_next     = SHADOW;
         end
      end
   end

   assign stall_inc = (if_ctrl.stall == ENABLE);

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (stall_inc),
      .count (stall_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (redirect_inc),
      .count (redirect_count)
   );

   // Counters read as zero throughout reset, even before the first edge.
   assign stall_cycles = reset ? '0 : stall_count;
   assign redirect_cnt = reset ? '0 : redirect_count;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
module tb_fetch_hazard_ctrl;
   import definitions::*;

   localparam int PC_W  = 8;
   localparam int RW    = 3;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic            clk;
   logic            reset;
   logic            id_valid;
   logic [RW-1:0]   id_rs1;
   logic [RW-1:0]   id_rs2;
   logic            id_uses_rs1;
   logic            id_uses_rs2;
   logic            id_jmp;
   logic [PC_W-1:0] id_jmp_target;
   logic            ex_valid;
   logic            ex_mem_read;
   logic [RW-1:0]   ex_rd;
   logic            ex_branch;
   logic            ex_alu_zero;
   logic [PC_W-1:0] ex_branch_target;
   logic            ex_busy;
   IF_input         if_ctrl;
   logic            flush_ifid;
   logic            flush_idex;
   logic            hold_ifid;
   logic            hold_idex;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] redirect_cnt;

   int checks = 0;
   int errors = 0;

   fetch_hazard_ctrl #(.PC_W(PC_W), .REG_W(RW), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .id_valid         (id_valid),
      .id_rs1           (id_rs1),
      .id_rs2           (id_rs2),
      .id_uses_rs1      (id_uses_rs1),
      .id_uses_rs2      (id_uses_rs2),
      .id_jmp           (id_jmp),
      .id_jmp_target    (id_jmp_target),
      .ex_valid         (ex_valid),
      .ex_mem_read      (ex_mem_read),
      .ex_rd            (ex_rd),
      .ex_branch        (ex_branch),
      .ex_alu_zero      (ex_alu_zero),
      .ex_branch_target (ex_branch_target),
      .ex_busy          (ex_busy),
      .if_ctrl          (if_ctrl),
      .flush_ifid       (flush_ifid),
      .flush_idex       (flush_idex),
      .hold_ifid        (hold_ifid),
      .hold_idex        (hold_idex),
      .stall_cycles     (stall_cycles),
      .redirect_cnt     (redirect_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Hazard outcome from the rules: busy beats taken branch beats load-use
   // beats jump; a cycle following a redirect ignores ID-side hazards.
   logic    m_shadow = 1'b0;
   int      m_stall  = 0;
   int      m_redir  = 0;
   logic    e_stall_ev;
   logic    e_redir_ev;
   IF_input e_if;
   logic    e_fifid, e_fidex, e_hifid, e_hidex;

   always @(negedge clk) begin
      logic taken, lu, jp;
      e_if       = '0;
      e_fifid    = 0; e_fidex = 0; e_hifid = 0; e_hidex = 0;
      e_stall_ev = 0; e_redir_ev = 0;
      taken = ex_valid && ex_branch && ex_alu_zero;
      lu    = !m_shadow && ex_valid && ex_mem_read && id_valid &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      jp    = !m_shadow && id_valid && id_jmp;
      if (!reset) begin
         if (ex_busy) begin
            e_if.stall = ENABLE; e_hifid = 1; e_hidex = 1; e_stall_ev = 1;
         end else begin
            e_if.branch   = (ex_valid && ex_branch) ? ENABLE : DISABLE;
            e_if.alu_zero = taken;
            if (taken) begin
               e_if.pc_branch = ex_branch_target;
               e_fifid = 1; e_fidex = 1; e_redir_ev = 1;
            end else if (lu) begin
               e_if.stall = ENABLE; e_hifid = 1; e_fidex = 1; e_stall_ev = 1;
            end else if (jp) begin
               e_if.jmp = ENABLE; e_if.pc_jmp = id_jmp_target;
               e_fifid = 1; e_redir_ev = 1;
            end
         end
      end
      check("if_ctrl",      32'(if_ctrl),      32'(e_if));
      check("flush_ifid",   32'(flush_ifid),   32'(e_fifid));
      check("flush_idex",   32'(flush_idex),   32'(e_fidex));
      check("hold_ifid",    32'(hold_ifid),    32'(e_hifid));
      check("hold_idex",    32'(hold_idex),    32'(e_hidex));
      check("stall_cycles", 32'(stall_cycles), reset ? 32'd0 : 32'(m_stall));
      check("redirect_cnt", 32'(redirect_cnt), reset ? 32'd0 : 32'(m_redir));
   end

   always @(posedge clk) begin
      if (reset) begin
         m_shadow <= 1'b0;
         m_stall  <= 0;
         m_redir  <= 0;
      end else begin
         m_shadow <= e_redir_ev;
         if (e_stall_ev && m_stall < CMAX) m_stall <= m_stall + 1;
         if (e_redir_ev && m_redir < CMAX) m_redir <= m_redir + 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_jmp = 0; id_jmp_target = 0; ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
      ex_branch = 0; ex_alu_zero = 0; ex_branch_target = 0; ex_busy = 0;
   endtask

   // Advance to just after the next rising edge; inputs change there.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cyc(); idle(); reset = 1;
      cyc(); reset = 0;
   endtask

   initial begin
      reset = 1;
      idle();
      ex_busy = 1;
      // Reset held two cycles with busy asserted: everything reads zero.
      for (int i = 0; i < 2; i++) begin
         #3;
         check("rst_if_ctrl", 32'(if_ctrl), 32'd0);
         check("rst_stall",   32'(stall_cycles), 32'd0);
         check("rst_hold",    {30'd0, hold_ifid, hold_idex}, 32'd0);
         $display("txn reset cycle %0d if_ctrl=0x%0h", i, if_ctrl);
         cyc();
      end
      // First cycle after release: a jump must act (state is RUN).
      reset = 0; idle();
      id_valid = 1; id_jmp = 1; id_jmp_target = 8'h10;
      #3;
      check("jmp_en",     32'(if_ctrl.jmp), 32'(ENABLE));
      check("jmp_pc",     32'(if_ctrl.pc_jmp), 32'h10);
      check("jmp_fifid",  32'(flush_ifid), 32'd1);
      check("jmp_fidex",  32'(flush_idex), 32'd0);
      $display("txn jump target=0x10 jmp=%0d pc_jmp=0x%0h", if_ctrl.jmp, if_ctrl.pc_jmp);

      // Load-use on rs2.
      do_reset();
      ex_valid = 1; ex_mem_read = 1; ex_rd = 3;
      id_valid = 1; id_rs2 = 3; id_uses_rs2 = 1;
      #3;
      check("lu_stall", 32'(if_ctrl.stall), 32'(ENABLE));
      check("lu_fidex", 32'(flush_idex), 32'd1);
      $display("txn load-use rd=3 stall=%0d", if_ctrl.stall);
      cyc(); id_uses_rs2 = 0;
      #3;
      check("lu_unused_stall", 32'(if_ctrl.stall), 32'(DISABLE));
      cyc(); idle();
      #3;
      check("lu_stall_cnt", 32'(stall_cycles), 32'd1);
      $display("txn load-use done stall_cycles=%0d", stall_cycles);

      // Taken branch and jump together; then squashed jump.
      do_reset();
      ex_valid = 1; ex_branch = 1; ex_alu_zero = 1; ex_branch_target = 8'h40;
      id_valid = 1; id_jmp = 1; id_jmp_target = 8'h22;
      #3;
      check("br_pc",    32'(if_ctrl.pc_branch), 32'h40);
      check("br_jmp",   32'(if_ctrl.jmp), 32'(DISABLE));
      check("br_flush", {30'd0, flush_ifid, flush_idex}, 32'd3);
      $display("txn branch+jump pc_branch=0x%0h", if_ctrl.pc_branch);
      cyc(); ex_valid = 0; ex_branch = 0; ex_alu_zero = 0;
      #3;
      check("shadow_jmp", 32'(if_ctrl.jmp), 32'(DISABLE));
      cyc(); idle();
      #3;
      check("br_redir_cnt", 32'(redirect_cnt), 32'd1);
      $display("txn shadow done redirect_cnt=%0d", redirect_cnt);

      // Busy 4 cycles with a taken branch waiting.
      do_reset();
      ex_valid = 1; ex_branch = 1; ex_alu_zero = 1; ex_branch_target = 8'h5c;
      ex_busy = 1;
      for (int i = 0; i < 4; i++) begin
         #3;
         check("busy_stall", 32'(if_ctrl.stall), 32'(ENABLE));
         check("busy_nobr",  32'(if_ctrl.pc_branch), 32'd0);
         cyc();
      end
      ex_busy = 0;
      #3;
      check("busy_br_pc",  32'(if_ctrl.pc_branch), 32'h5c);
      check("busy_br_fl",  {30'd0, flush_ifid, flush_idex}, 32'd3);
      check("busy_stall_cnt", 32'(stall_cycles), 32'd4);
      $display("txn busy x4 then branch stall_cycles=%0d", stall_cycles);

      // Saturation.
      do_reset();
      ex_busy = 1;
      for (int i = 0; i < CMAX + 3; i++) cyc();
      #3;
      check("sat_stall", 32'(stall_cycles), 32'(CMAX));
      $display("txn saturation stall_cycles=%0d", stall_cycles);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         reset            = ($urandom_range(0, 63) == 0);
         id_valid         = ($urandom_range(0, 3) != 0);
         id_rs1           = RW'($urandom_range(0, 3));
         id_rs2           = RW'($urandom_range(0, 3));
         id_uses_rs1      = $urandom_range(0, 1);
         id_uses_rs2      = $urandom_range(0, 1);
         id_jmp           = ($urandom_range(0, 4) == 0);
         id_jmp_target    = PC_W'($urandom);
         ex_valid         = ($urandom_range(0, 3) != 0);
         ex_mem_read      = ($urandom_range(0, 2) == 0);
         ex_rd            = RW'($urandom_range(0, 3));
         ex_branch        = ($urandom_range(0, 3) == 0);
         ex_alu_zero      = $urandom_range(0, 1);
         ex_branch_target = PC_W'($urandom);
         ex_busy          = ($urandom_range(0, 7) == 0);
         if (n % 500 == 0)
            $display("txn random %0d stall_cycles=%0d redirect_cnt=%0d", n, stall_cycles, redirect_cnt);
         cyc();
      end
      idle();
      cyc();
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
